// File: rtl/ycbcr_skin_bbox_if.sv
// ----------------------------------------------------------------------------
// ycbcr_skin_bbox_if
//  Bundles the video stream entering the skin classifier (Y/Cb/Cr plus timing)
//  and everything it produces (binary mask video, per-frame count and bounding
//  box, publish strobe).
//  master : the video source / result consumer (drives iY..iVSync)
//  slave  : the classifier (drives oR..oValid)
// ----------------------------------------------------------------------------
interface ycbcr_skin_bbox_if #(
    parameter int XW   = 11,
    parameter int YW   = 11,
    parameter int CNTW = 22
) ();
    logic [7:0]      iY;
    logic [7:0]      iCb;
    logic [7:0]      iCr;
    logic            iDE;
    logic            iHSync;
    logic            iVSync;

    logic [7:0]      oR;
    logic [7:0]      oG;
    logic [7:0]      oB;
    logic            oDE;
    logic            oHSync;
    logic            oVSync;
    logic [CNTW-1:0] oCount;
    logic [XW-1:0]   oXMin;
    logic [XW-1:0]   oXMax;
    logic [YW-1:0]   oYMin;
    logic [YW-1:0]   oYMax;
    logic            oValid;

    modport master (
        output iY, iCb, iCr, iDE, iHSync, iVSync,
        input  oR, oG, oB, oDE, oHSync, oVSync,
        input  oCount, oXMin, oXMax, oYMin, oYMax, oValid
    );

    modport slave (
        input  iY, iCb, iCr, iDE, iHSync, iVSync,
        output oR, oG, oB, oDE, oHSync, oVSync,
        output oCount, oXMin, oXMax, oYMin, oYMax, oValid
    );
endinterface

// File: rtl/ycbcr_skin_bbox.sv
// ----------------------------------------------------------------------------
// ycbcr_skin_bbox
//  Classifies each active Y/Cb/Cr pixel against an inclusive skin window and
//  outputs a 0/255 mask video with timing delayed by the same two enabled
//  cycles. Per frame it counts mask pixels and tracks their bounding box,
//  publishing both (with a one-clock oValid) on every VSync rising edge.
// Ports
//  iClk  : clock
//  iRst  : synchronous reset, active low
//  iCe   : clock enable, 0 freezes everything except the oValid pulse
//  bus   : slave side of ycbcr_skin_bbox_if (video in, mask video + stats out)
// ----------------------------------------------------------------------------
module ycbcr_skin_bbox #(
    parameter int Y_MIN  = 16,
    parameter int CB_MIN = 77,
    parameter int CB_MAX = 127,
    parameter int CR_MIN = 133,
    parameter int CR_MAX = 173,
    parameter int XW     = 11,
    parameter int YW     = 11,
    parameter int CNTW   = 22
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iCe,
    ycbcr_skin_bbox_if.slave   bus
);
    localparam logic [7:0] LP_Y_MIN  = Y_MIN[7:0];
    localparam logic [7:0] LP_CB_MIN = CB_MIN[7:0];
    localparam logic [7:0] LP_CB_MAX = CB_MAX[7:0];
    localparam logic [7:0] LP_CR_MIN = CR_MIN[7:0];
    localparam logic [7:0] LP_CR_MAX = CR_MAX[7:0];

    typedef enum logic {WAIT_VS = 1'b0, ACTIVE = 1'b1} state_t;

    state_t          r_state;
    // stage 1
    logic            r_s1_m, r_s1_de, r_s1_hs, r_s1_vs;
    logic            r_vs_prev, r_de_prev;
    // stage 2 / outputs
    logic            r_mask, r_de_o, r_hs_o, r_vs_o, r_valid;
    logic [CNTW-1:0] r_count_o;
    logic [XW-1:0]   r_xmin_o, r_xmax_o;
    logic [YW-1:0]   r_ymin_o, r_ymax_o;
    // coordinates and accumulators
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CNTW-1:0] r_cnt;
    logic [XW-1:0]   r_xmin, r_xmax;
    logic [YW-1:0]   r_ymin, r_ymax;

    logic            w_m_in, w_vs_edge, w_de_fall, w_take;
    logic [YW-1:0]   w_y_cur;
    logic [CNTW-1:0] w_cnt_base, w_cnt_next;
    logic [XW-1:0]   w_xmin_base, w_xmax_base, w_xmin_next, w_xmax_next;
    logic [YW-1:0]   w_ymin_base, w_ymax_base, w_ymin_next, w_ymax_next;

    assign w_m_in = bus.iDE
                  & (bus.iY  >= LP_Y_MIN)
                  & (bus.iCb >= LP_CB_MIN) & (bus.iCb <= LP_CB_MAX)
                  & (bus.iCr >= LP_CR_MIN) & (bus.iCr <= LP_CR_MAX);

    always_comb begin
        w_vs_edge   = r_s1_vs & ~r_vs_prev;
        w_de_fall   = ~r_s1_de & r_de_prev;
        // A pixel coinciding with the VSync edge is row 0 of the new frame.
        w_y_cur     = w_vs_edge ? '0 : r_y;
        // In WAIT_VS only the edge cycle itself may contribute (new frame).
        w_take      = r_s1_m & ((r_state == ACTIVE) | w_vs_edge);
        w_cnt_base  = w_vs_edge ? '0 : r_cnt;
        w_xmin_base = w_vs_edge ? '1 : r_xmin;
        w_xmax_base = w_vs_edge ? '0 : r_xmax;
        w_ymin_base = w_vs_edge ? '1 : r_ymin;
        w_ymax_base = w_vs_edge ? '0 : r_ymax;
        w_cnt_next  = w_cnt_base;
        w_xmin_next = w_xmin_base;
        w_xmax_next = w_xmax_base;
        w_ymin_next = w_ymin_base;
        w_ymax_next = w_ymax_base;
        if (w_take) begin
            if (w_cnt_base != '1)       w_cnt_next  = w_cnt_base + CNTW'(1);
            if (r_x < w_xmin_base)      w_xmin_next = r_x;
            if (r_x > w_xmax_base)      w_xmax_next = r_x;
            if (w_y_cur < w_ymin_base)  w_ymin_next = w_y_cur;
            if (w_y_cur > w_ymax_base)  w_ymax_next = w_y_cur;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state   <= WAIT_VS;
            r_s1_m    <= 1'b0;
            r_s1_de   <= 1'b0;
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_vs_prev <= 1'b0;
            r_de_prev <= 1'b0;
            r_mask    <= 1'b0;
            r_de_o    <= 1'b0;
            r_hs_o    <= 1'b0;
            r_vs_o    <= 1'b0;
            r_valid   <= 1'b0;
            r_count_o <= '0;
            r_xmin_o  <= '0;
            r_xmax_o  <= '0;
            r_ymin_o  <= '0;
            r_ymax_o  <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_xmin    <= '1;
            r_xmax    <= '0;
            r_ymin    <= '1;
            r_ymax    <= '0;
        end else begin
            // The strobe is a single clock wide even while stalled.
            r_valid <= 1'b0;
            if (iCe) begin
                r_s1_m    <= w_m_in;
                r_s1_de   <= bus.iDE;
                r_s1_hs   <= bus.iHSync;
                r_s1_vs   <= bus.iVSync;
                r_vs_prev <= r_s1_vs;
                r_de_prev <= r_s1_de;

                r_mask    <= r_s1_m;
                r_de_o    <= r_s1_de;
                r_hs_o    <= r_s1_hs;
                r_vs_o    <= r_s1_vs;

                // r_x is the column of the current S1 pixel; it idles at 0
                // outside DE so the first pixel of each line sees 0.
                if (r_s1_de) begin
                    if (r_x != '1) r_x <= r_x + XW'(1);
                end else begin
                    r_x <= '0;
                end

                if (w_vs_edge) begin
                    r_y <= '0;
                end else if (w_de_fall && (r_y != '1)) begin
                    r_y <= r_y + YW'(1);
                end

                case (r_state)
                    WAIT_VS: begin
                        if (w_vs_edge) begin
                            r_state <= ACTIVE;
                            r_cnt   <= w_cnt_next;
                            r_xmin  <= w_xmin_next;
                            r_xmax  <= w_xmax_next;
                            r_ymin  <= w_ymin_next;
                            r_ymax  <= w_ymax_next;
                        end
                    end
                    ACTIVE: begin
                        r_cnt  <= w_cnt_next;
                        r_xmin <= w_xmin_next;
                        r_xmax <= w_xmax_next;
                        r_ymin <= w_ymin_next;
                        r_ymax <= w_ymax_next;
                        if (w_vs_edge) begin
                            r_count_o <= r_cnt;
                            r_xmin_o  <= r_xmin;
                            r_xmax_o  <= r_xmax;
                            r_ymin_o  <= r_ymin;
                            r_ymax_o  <= r_ymax;
                            r_valid   <= 1'b1;
                        end
                    end
                    default: r_state <= WAIT_VS;
                endcase
            end
        end
    end

    assign bus.oR     = {8{r_mask}};
    assign bus.oG     = {8{r_mask}};
    assign bus.oB     = {8{r_mask}};
    assign bus.oDE    = r_de_o;
    assign bus.oHSync = r_hs_o;
    assign bus.oVSync = r_vs_o;
    assign bus.oCount = r_count_o;
    assign bus.oXMin  = r_xmin_o;
    assign bus.oXMax  = r_xmax_o;
    assign bus.oYMin  = r_ymin_o;
    assign bus.oYMax  = r_ymax_o;
    assign bus.oValid = r_valid;
endmodule
